// File: rtl/titles_scheduler.sv
// rtl/titles_scheduler.sv - frame-synchronous title layer sequencer (attract/play/game-over)
module titles_scheduler #(
  parameter int BLINK_FRAMES  = 30,
  parameter int REVEAL_FRAMES = 8,
  parameter int OVER_CHARS    = 9,
  parameter int HOLD_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameEnded,
  input  logic       standBy,
  output logic       highEn,
  output logic       scoreEn,
  output logic       creditEn,
  output logic       livesEn,
  output logic       playGame,
  output logic [3:0] revealChars,
  output logic       revealDone,
  output logic [1:0] titlesState
);

  typedef enum logic [1:0] {
    ST_STANDBY = 2'd0,
    ST_PLAY    = 2'd1,
    ST_REVEAL  = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] REVEAL_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0] CHARS_ALL   = 4'(OVER_CHARS);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic [3:0] reveal_q, reveal_d;
  logic       done_q, done_d;
  logic       high_q, high_d;
  logic       score_q, score_d;
  logic       credit_q, credit_d;
  logic       lives_q, lives_d;
  logic       play_q, play_d;
  logic       step_reveal;

  // Next-state, counters and output decode; everything holds between frame pulses.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    reveal_d    = reveal_q;
    done_d      = done_q;
    high_d      = high_q;
    score_d     = score_q;
    credit_d    = credit_q;
    lives_d     = lives_q;
    play_d      = play_q;
    step_reveal = 1'b0;

    if (startOfFrame) begin
      if (standBy) begin
        state_d = ST_STANDBY;
      end else begin
        case (state_q)
          ST_STANDBY: if (!gameEnded) state_d = ST_PLAY;
          ST_PLAY:    if (gameEnded) state_d = ST_REVEAL;
          ST_REVEAL: begin
            if (frame_cnt_q == REVEAL_LAST) begin
              if (reveal_q + 4'd1 == CHARS_ALL) state_d = ST_HOLD;
              else                              step_reveal = 1'b1;
            end
          end
          ST_HOLD: begin
            if (!gameEnded)                    state_d = ST_PLAY;
            else if (frame_cnt_q == HOLD_LAST) state_d = ST_STANDBY;
          end
          default: state_d = ST_STANDBY;
        endcase
      end

      // Frame counter restarts on every state change and on each revealed character.
      if ((state_d != state_q) || step_reveal) begin
        frame_cnt_d = 8'd0;
      end else if (frame_cnt_q != 8'hFF) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end

      // Credit blink restarts visible whenever attract is (re)entered.
      if (state_d == ST_STANDBY) begin
        if (state_q != ST_STANDBY) begin
          blink_cnt_d = 8'd0;
          blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = 8'd0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 8'd1;
        end
      end

      high_d   = 1'b1;
      score_d  = 1'b1;
      credit_d = 1'b1;
      lives_d  = 1'b1;
      play_d   = 1'b0;
      reveal_d = 4'd0;
      done_d   = 1'b0;
      case (state_d)
        ST_STANDBY: begin
          credit_d = blink_on_d;
          lives_d  = 1'b0;
        end
        ST_PLAY: play_d = 1'b1;
        ST_REVEAL: begin
          if (state_q == ST_REVEAL) reveal_d = step_reveal ? reveal_q + 4'd1 : reveal_q;
        end
        ST_HOLD: begin
          reveal_d = CHARS_ALL;
          done_d   = 1'b1;
        end
        default: reveal_d = 4'd0;
      endcase
    end
  end

  // State, counters and registered outputs with asynchronous reset to attract.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_STANDBY;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      blink_on_q  <= 1'b1;
      reveal_q    <= 4'd0;
      done_q      <= 1'b0;
      high_q      <= 1'b1;
      score_q     <= 1'b1;
      credit_q    <= 1'b1;
      lives_q     <= 1'b0;
      play_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      reveal_q    <= reveal_d;
      done_q      <= done_d;
      high_q      <= high_d;
      score_q     <= score_d;
      credit_q    <= credit_d;
      lives_q     <= lives_d;
      play_q      <= play_d;
    end
  end

  assign highEn      = high_q;
  assign scoreEn     = score_q;
  assign creditEn    = credit_q;
  assign livesEn     = lives_q;
  assign playGame    = play_q;
  assign revealChars = reveal_q;
  assign revealDone  = done_q;
  assign titlesState = state_q;

endmodule
